id_ex_stage: RTL and testbench

ID/EX pipeline stage sitting directly upstream of the EX-stage ALU. It registers decoded operands and control fields from decode, resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand inputs `entrada1`/`entrada2` and `ALUControl`. It also flags load-use hazards back to decode, supports stall (hold) and flush (bubble), and carries store data and memory/writeback control forward.

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: captures decoded fields,
// forwards EX/MEM and MEM/WB results onto the operands, and flags load-use hazards.
module id_ex_stage #(
    parameter int LARGURA   = 16,
    parameter int NREG_BITS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valido,
    input  logic [NREG_BITS-1:0] in_rs1,
    input  logic [NREG_BITS-1:0] in_rs2,
    input  logic [LARGURA-1:0]   in_dado1,
    input  logic [LARGURA-1:0]   in_dado2,
    input  logic [LARGURA-1:0]   in_imediato,
    input  logic                 in_usa_imediato,
    input  logic [2:0]           in_ALUControl,
    input  logic [NREG_BITS-1:0] in_rd,
    input  logic                 in_escreve_reg,
    input  logic                 in_le_mem,
    input  logic                 in_escreve_mem,
    input  logic [NREG_BITS-1:0] exmem_rd,
    input  logic                 exmem_escreve_reg,
    input  logic [LARGURA-1:0]   exmem_resultado,
    input  logic [NREG_BITS-1:0] memwb_rd,
    input  logic                 memwb_escreve_reg,
    input  logic [LARGURA-1:0]   memwb_dado,
    output logic [LARGURA-1:0]   entrada1,
    output logic [LARGURA-1:0]   entrada2,
    output logic [2:0]           ALUControl,
    output logic [LARGURA-1:0]   dado_store,
    output logic [NREG_BITS-1:0] rd,
    output logic                 escreve_reg,
    output logic                 le_mem,
    output logic                 escreve_mem,
    output logic                 valido,
    output logic                 hazard_carga
);

    logic                 r_valido;
    logic [NREG_BITS-1:0] r_rs1;
    logic [NREG_BITS-1:0] r_rs2;
    logic [LARGURA-1:0]   r_dado1;
    logic [LARGURA-1:0]   r_dado2;
    logic [LARGURA-1:0]   r_imediato;
    logic                 r_usa_imediato;
    logic [2:0]           r_alu;
    logic [NREG_BITS-1:0] r_rd;
    logic                 r_escreve_reg;
    logic                 r_le_mem;
    logic                 r_escreve_mem;

    logic [LARGURA-1:0]   w_fwd1;
    logic [LARGURA-1:0]   w_fwd2;
    logic [LARGURA-1:0]   w_cap1;
    logic [LARGURA-1:0]   w_cap2;

    // EX/MEM wins over MEM/WB because it is the younger producer; r0 is never forwarded.
    function automatic logic [LARGURA-1:0] forward(
        input logic [NREG_BITS-1:0] rs,
        input logic [LARGURA-1:0]   registrado
    );
        if (rs != '0 && exmem_escreve_reg && exmem_rd == rs)
            return exmem_resultado;
        else if (rs != '0 && memwb_escreve_reg && memwb_rd == rs)
            return memwb_dado;
        else
            return registrado;
    endfunction

    // A register-file write in the same cycle as decode is not yet visible in in_dadoX.
    function automatic logic [LARGURA-1:0] capture(
        input logic [NREG_BITS-1:0] rs,
        input logic [LARGURA-1:0]   lido
    );
        if (rs != '0 && memwb_escreve_reg && memwb_rd == rs)
            return memwb_dado;
        else
            return lido;
    endfunction

    assign w_fwd1 = forward(r_rs1, r_dado1);
    assign w_fwd2 = forward(r_rs2, r_dado2);
    assign w_cap1 = capture(in_rs1, in_dado1);
    assign w_cap2 = capture(in_rs2, in_dado2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valido       <= 1'b0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_dado1        <= '0;
            r_dado2        <= '0;
            r_imediato     <= '0;
            r_usa_imediato <= 1'b0;
            r_alu          <= '0;
            r_rd           <= '0;
            r_escreve_reg  <= 1'b0;
            r_le_mem       <= 1'b0;
            r_escreve_mem  <= 1'b0;
        end else if (flush) begin
            r_valido       <= 1'b0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_dado1        <= '0;
            r_dado2        <= '0;
            r_imediato     <= '0;
            r_usa_imediato <= 1'b0;
            r_alu          <= '0;
            r_rd           <= '0;
            r_escreve_reg  <= 1'b0;
            r_le_mem       <= 1'b0;
            r_escreve_mem  <= 1'b0;
        end else if (stall) begin
            // Latch forwarded values so a producer retiring during the stall is not lost.
            r_dado1 <= w_fwd1;
            r_dado2 <= w_fwd2;
        end else begin
            r_valido       <= in_valido;
            r_rs1          <= in_rs1;
            r_rs2          <= in_rs2;
            r_dado1        <= w_cap1;
            r_dado2        <= w_cap2;
            r_imediato     <= in_imediato;
            r_usa_imediato <= in_usa_imediato;
            r_alu          <= in_ALUControl;
            r_rd           <= in_rd;
            r_escreve_reg  <= in_escreve_reg;
            r_le_mem       <= in_le_mem;
            r_escreve_mem  <= in_escreve_mem;
        end
    end

    assign entrada1    = w_fwd1;
    assign entrada2    = r_usa_imediato ? r_imediato : w_fwd2;
    assign dado_store  = w_fwd2;
    assign ALUControl  = r_alu;
    assign rd          = r_rd;
    assign valido      = r_valido;
    assign escreve_reg = r_valido & r_escreve_reg;
    assign le_mem      = r_valido & r_le_mem;
    assign escreve_mem = r_valido & r_escreve_mem;

    assign hazard_carga = r_valido & r_le_mem & (r_rd != '0) & in_valido &
                          ((r_rd == in_rs1) | (r_rd == in_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, immediates, load-use,
// stall retention, flush priority and asynchronous reset.
module tb_id_ex_stage;

    localparam int LARGURA   = 16;
    localparam int NREG_BITS = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 stall, flush, in_valido;
    logic [NREG_BITS-1:0] in_rs1, in_rs2, in_rd;
    logic [LARGURA-1:0]   in_dado1, in_dado2, in_imediato;
    logic                 in_usa_imediato;
    logic [2:0]           in_ALUControl;
    logic                 in_escreve_reg, in_le_mem, in_escreve_mem;
    logic [NREG_BITS-1:0] exmem_rd, memwb_rd;
    logic                 exmem_escreve_reg, memwb_escreve_reg;
    logic [LARGURA-1:0]   exmem_resultado, memwb_dado;
    logic [LARGURA-1:0]   entrada1, entrada2, dado_store;
    logic [2:0]           ALUControl;
    logic [NREG_BITS-1:0] rd;
    logic                 escreve_reg, le_mem, escreve_mem, valido, hazard_carga;

    int vectors = 0;
    int miscompares = 0;

    id_ex_stage #(.LARGURA(LARGURA), .NREG_BITS(NREG_BITS)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valido(in_valido), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_dado1(in_dado1), .in_dado2(in_dado2), .in_imediato(in_imediato),
        .in_usa_imediato(in_usa_imediato), .in_ALUControl(in_ALUControl),
        .in_rd(in_rd), .in_escreve_reg(in_escreve_reg), .in_le_mem(in_le_mem),
        .in_escreve_mem(in_escreve_mem), .exmem_rd(exmem_rd),
        .exmem_escreve_reg(exmem_escreve_reg), .exmem_resultado(exmem_resultado),
        .memwb_rd(memwb_rd), .memwb_escreve_reg(memwb_escreve_reg),
        .memwb_dado(memwb_dado), .entrada1(entrada1), .entrada2(entrada2),
        .ALUControl(ALUControl), .dado_store(dado_store), .rd(rd),
        .escreve_reg(escreve_reg), .le_mem(le_mem), .escreve_mem(escreve_mem),
        .valido(valido), .hazard_carga(hazard_carga)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valido = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_dado1 = 0; in_dado2 = 0; in_imediato = 0; in_usa_imediato = 0;
        in_ALUControl = 0; in_escreve_reg = 0; in_le_mem = 0; in_escreve_mem = 0;
        exmem_rd = 0; exmem_escreve_reg = 0; exmem_resultado = 0;
        memwb_rd = 0; memwb_escreve_reg = 0; memwb_dado = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        stall = 1'($urandom); flush = 1'($urandom); in_valido = 1;
        in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_rd = 3'($urandom);
        in_dado1 = 16'($urandom); in_dado2 = 16'($urandom); in_imediato = 16'($urandom);
        in_usa_imediato = 1'($urandom); in_ALUControl = 3'($urandom);
        in_escreve_reg = 1; in_le_mem = 1; in_escreve_mem = 1;
        exmem_rd = 3'($urandom); exmem_escreve_reg = 1; exmem_resultado = 16'($urandom);
        memwb_rd = 3'($urandom); memwb_escreve_reg = 1; memwb_dado = 16'($urandom);
        tick(); tick();
        vectors++;
        if ({entrada1, entrada2, dado_store} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_operands: got %h %h %h, expected 0 0 0", entrada1, entrada2, dado_store);
        end
        vectors++;
        if ({valido, escreve_reg, le_mem, escreve_mem, hazard_carga, rd, ALUControl} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got v=%b w=%b l=%b s=%b h=%b rd=%0d alu=%b, expected all 0",
                     valido, escreve_reg, le_mem, escreve_mem, hazard_carga, rd, ALUControl);
        end
        idle_inputs();
        #2 reset = 1;
        in_valido = 1; in_rs1 = 1; in_rs2 = 2; in_dado1 = 16'h0003; in_dado2 = 16'h0001;
        in_ALUControl = 3'b010; in_usa_imediato = 0;
        tick();
        vectors++;
        if (entrada1 !== 16'h0003 || entrada2 !== 16'h0001) begin
            miscompares++;
            $display("FAIL first_load_ops: got %h %h, expected 0003 0001", entrada1, entrada2);
        end
        vectors++;
        if (ALUControl !== 3'b010 || valido !== 1'b1) begin
            miscompares++;
            $display("FAIL first_load_ctrl: got alu=%b v=%b, expected alu=010 v=1", ALUControl, valido);
        end
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        in_valido = 1; in_rs1 = 2; in_dado1 = 16'h0011;
        tick();
        exmem_rd = 2; exmem_escreve_reg = 1; exmem_resultado = 16'h00AA;
        memwb_rd = 2; memwb_escreve_reg = 1; memwb_dado = 16'h0055;
        #1;
        vectors++;
        if (entrada1 !== 16'h00AA) begin
            miscompares++;
            $display("FAIL fwd_exmem_prio: got %h, expected 00AA", entrada1);
        end
        exmem_escreve_reg = 0;
        #1;
        vectors++;
        if (entrada1 !== 16'h0055) begin
            miscompares++;
            $display("FAIL fwd_memwb: got %h, expected 0055", entrada1);
        end
        memwb_escreve_reg = 0;
        #1;
        vectors++;
        if (entrada1 !== 16'h0011) begin
            miscompares++;
            $display("FAIL fwd_none: got %h, expected 0011", entrada1);
        end
        // r0 source: both producers claim r0 but must be ignored
        in_rs1 = 0; in_dado1 = 16'h0007;
        tick();
        exmem_rd = 0; exmem_escreve_reg = 1; exmem_resultado = 16'h00AA;
        memwb_rd = 0; memwb_escreve_reg = 1; memwb_dado = 16'h0055;
        #1;
        vectors++;
        if (entrada1 !== 16'h0007) begin
            miscompares++;
            $display("FAIL fwd_r0: got %h, expected 0007", entrada1);
        end
    endtask

    task automatic test_capture_bypass();
        idle_inputs();
        in_valido = 1; in_rs1 = 4; in_dado1 = 16'h1111;
        memwb_rd = 4; memwb_escreve_reg = 1; memwb_dado = 16'h2222;
        tick();
        memwb_escreve_reg = 0; memwb_dado = 16'h0000;
        #1;
        vectors++;
        if (entrada1 !== 16'h2222) begin
            miscompares++;
            $display("FAIL capture_bypass: got %h, expected 2222", entrada1);
        end
    endtask

    task automatic test_immediate_store();
        idle_inputs();
        in_valido = 1; in_rs2 = 5; in_dado2 = 16'h0009;
        in_usa_imediato = 1; in_imediato = 16'hFFF0;
        tick();
        exmem_rd = 5; exmem_escreve_reg = 1; exmem_resultado = 16'h1234;
        #1;
        vectors++;
        if (entrada2 !== 16'hFFF0) begin
            miscompares++;
            $display("FAIL imm_entrada2: got %h, expected FFF0", entrada2);
        end
        vectors++;
        if (dado_store !== 16'h1234) begin
            miscompares++;
            $display("FAIL store_fwd: got %h, expected 1234", dado_store);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        in_valido = 1; in_le_mem = 1; in_escreve_reg = 1; in_rd = 3;
        tick();
        vectors++;
        if (le_mem !== 1'b1 || escreve_reg !== 1'b1 || rd !== 3'd3) begin
            miscompares++;
            $display("FAIL load_captured: got l=%b w=%b rd=%0d, expected 1 1 3", le_mem, escreve_reg, rd);
        end
        in_le_mem = 0; in_escreve_reg = 0; in_rd = 0;
        in_rs1 = 1; in_rs2 = 3; in_valido = 0;
        #1;
        vectors++;
        if (hazard_carga !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_invalid_dec: got %b, expected 0", hazard_carga);
        end
        in_valido = 1;
        #1;
        vectors++;
        if (hazard_carga !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_rs2: got %b, expected 1", hazard_carga);
        end
        flush = 1;
        tick();
        vectors++;
        if (valido !== 1'b0 || escreve_reg !== 1'b0 || le_mem !== 1'b0 || hazard_carga !== 1'b0) begin
            miscompares++;
            $display("FAIL hazard_flush: got v=%b w=%b l=%b h=%b, expected 0 0 0 0",
                     valido, escreve_reg, le_mem, hazard_carga);
        end
        // load to r0 never raises a hazard
        flush = 0; in_le_mem = 1; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        tick();
        vectors++;
        if (hazard_carga !== 1'b0 || le_mem !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_r0: got h=%b l=%b, expected h=0 l=1", hazard_carga, le_mem);
        end
    endtask

    task automatic test_stall_retention();
        idle_inputs();
        in_valido = 1; in_rs1 = 6; in_dado1 = 16'h0100; in_rd = 5;
        in_ALUControl = 3'b011; in_escreve_mem = 1;
        tick();
        stall = 1;
        memwb_rd = 6; memwb_escreve_reg = 1; memwb_dado = 16'h0BEE;
        in_rs1 = 1; in_dado1 = 16'hDEAD; in_ALUControl = 3'b111; in_rd = 7; in_escreve_mem = 0;
        #1;
        vectors++;
        if (entrada1 !== 16'h0BEE) begin
            miscompares++;
            $display("FAIL stall_fwd_c1: got %h, expected 0BEE", entrada1);
        end
        tick();
        memwb_rd = 2; memwb_dado = 16'h3333;
        for (int c = 2; c <= 3; c++) begin
            #1;
            vectors++;
            if (entrada1 !== 16'h0BEE) begin
                miscompares++;
                $display("FAIL stall_hold_c%0d: got %h, expected 0BEE", c, entrada1);
            end
            vectors++;
            if (ALUControl !== 3'b011 || rd !== 3'd5 || escreve_mem !== 1'b1 || valido !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_fields_c%0d: got alu=%b rd=%0d s=%b v=%b, expected 011 5 1 1",
                         c, ALUControl, rd, escreve_mem, valido);
            end
            tick();
        end
        stall = 0;
    endtask

    task automatic test_flush_and_async_reset();
        idle_inputs();
        in_valido = 1; in_escreve_reg = 1; in_rd = 4;
        tick();
        flush = 1; stall = 1;
        tick();
        vectors++;
        if (valido !== 1'b0 || escreve_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_over_stall: got v=%b w=%b, expected 0 0", valido, escreve_reg);
        end
        flush = 0; stall = 0;
        in_rs1 = 1; in_dado1 = 16'h00F0; in_ALUControl = 3'b101; in_rd = 6;
        tick();
        vectors++;
        if (valido !== 1'b1 || entrada1 !== 16'h00F0 || rd !== 3'd6) begin
            miscompares++;
            $display("FAIL reload_after_flush: got v=%b e1=%h rd=%0d, expected 1 00F0 6", valido, entrada1, rd);
        end
        #2 reset = 0;
        #1;
        vectors++;
        if (valido !== 1'b0 || entrada1 !== 16'h0 || ALUControl !== 3'b0 || rd !== 3'd0 || escreve_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b e1=%h alu=%b rd=%0d w=%b, expected all 0",
                     valido, entrada1, ALUControl, rd, escreve_reg);
        end
        #3 reset = 1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forward_priority();
        test_capture_bypass();
        test_immediate_store();
        test_load_use();
        test_stall_retention();
        test_flush_and_async_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
